// File: rtl/sm_mult_seq.sv
// Sequential sign-magnitude fixed-point multiplier: shift-add one multiplier bit per cycle,
// then round half away from zero and saturate back to a W-bit sign-magnitude word.
module sm_mult_seq #(
    parameter int W    = 24,
    parameter int FRAC = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A_sm,
    input  logic [W-1:0] B_sm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] P_sm,
    output logic         sat
);
    localparam int CW  = (W > 2) ? $clog2(W - 1) : 1;
    localparam int AW  = 2 * W - 2;
    localparam int RW  = 2 * W - 1;
    localparam logic [RW-1:0] RND_CONST =
        (FRAC > 0) ? (RW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
    localparam logic [RW-1:0] MAG_MAX = {{W{1'b0}}, {(W-1){1'b1}}};
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 2);

    typedef enum logic [1:0] {IDLE, MUL, RND, OUT} state_t;

    state_t        state, state_next;
    logic [W-2:0]  mag_a, mag_b;
    logic          sign;
    logic [AW-1:0] acc;
    logic [CW-1:0] count;

    logic [AW-1:0] addend;
    logic [RW-1:0] rnd_sum;
    logic [RW-1:0] r_full;
    logic          r_sat;
    logic [W-2:0]  r_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = MUL;
            end
            MUL:  if (count == LAST_BIT) state_next = RND;
            RND:  state_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Partial product for the current multiplier bit; the rounding add gets one spare bit.
    assign addend  = {{(W-1){1'b0}}, mag_a} << count;
    assign rnd_sum = {1'b0, acc} + RND_CONST;
    assign r_full  = rnd_sum >> FRAC;
    assign r_sat   = (r_full > MAG_MAX);
    assign r_mag   = r_sat ? {(W-1){1'b1}} : r_full[W-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a <= '0;
            mag_b <= '0;
            sign  <= 1'b0;
            acc   <= '0;
            count <= '0;
            P_sm  <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mag_a <= A_sm[W-2:0];
                    mag_b <= B_sm[W-2:0];
                    sign  <= A_sm[W-1] ^ B_sm[W-1];
                    acc   <= '0;
                    count <= '0;
                end
                MUL: begin
                    if (mag_b[count]) acc <= acc + addend;
                    count <= count + CW'(1);
                end
                RND: begin
                    // A zero magnitude never carries a sign bit.
                    P_sm <= {(r_mag != '0) ? sign : 1'b0, r_mag};
                    sat  <= r_sat;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_mult_seq.sv
// Directed and random checks of sm_mult_seq (W=24, FRAC=12) against a behavioural
// reference held in a scoreboard queue.
module tb_sm_mult_seq;
    localparam int W    = 24;
    localparam int FRAC = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A_sm = '0;
    logic [W-1:0] B_sm = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] P_sm;
    logic         sat;

    int total = 0;
    int bad   = 0;
    logic [W:0] sb_q[$];

    sm_mult_seq #(.W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A_sm(A_sm), .B_sm(B_sm),
        .out_valid(out_valid), .out_ready(out_ready),
        .P_sm(P_sm), .sat(sat)
    );

    always #5 clk = ~clk;

    // Reference: {sat, P_sm}
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned prod, r;
        logic s;
        logic [W-2:0] m;
        prod = longint'(a[W-2:0]) * longint'(b[W-2:0]);
        r    = (prod + (longint'(1) << (FRAC - 1))) >> FRAC;
        s    = (r > longint'(24'h7FFFFF));
        m    = s ? 23'h7FFFFF : r[W-2:0];
        return {s, (m != 0) ? (a[W-1] ^ b[W-1]) : 1'b0, m};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction: accept, latency, optional backpressure, handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int bp);
        int cnt;
        logic [W:0] exp;
        cnt = 0;
        while (!in_ready && cnt < 60) begin
            @(posedge clk); #1; cnt++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        A_sm = a; B_sm = b; in_valid = 1'b1;
        sb_q.push_back(model(a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
        check("latency", 32'(cnt), 32'd24);
        exp = sb_q.pop_front();
        check("p_sm", 32'(P_sm), 32'(exp[W-1:0]));
        check("sat", 32'(sat), 32'(exp[W]));
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1; A_sm = ~a; B_sm = ~b;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_p_sm", 32'(P_sm), 32'(exp[W-1:0]));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_out_valid", 32'(out_valid), 32'd0);
        check("hs_in_ready", 32'(in_ready), 32'd1);
        check("hs_p_kept", 32'(P_sm), 32'(exp[W-1:0]));
        $display("op a=%h b=%h p=%h sat=%0d exp=%h/%0d", a, b, P_sm, sat, exp[W-1:0], exp[W]);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p_sm", 32'(P_sm), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(24'h001800, 24'h002000, 0);
        run_op(24'h801800, 24'h002000, 0);
        run_op(24'h801800, 24'h802000, 0);
        run_op(24'h000001, 24'h000800, 0);
        run_op(24'h000001, 24'h0007FF, 0);
        run_op(24'h800001, 24'h0007FF, 0);
        run_op(24'h800000, 24'h001000, 0);
        run_op(24'h7FFFFF, 24'h7FFFFF, 0);
        run_op(24'hFFFFFF, 24'h7FFFFF, 0);
        run_op(24'h003456, 24'h801234, 5);

        // Reset while multiplying at count=10
        A_sm = 24'h7FFFFF; B_sm = 24'h7FFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0; #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_p_sm", 32'(P_sm), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(24'h001800, 24'h802000, 0);

        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 3 == 0) ra[22:14] = '0;
            if (i % 4 == 0) rb[22:12] = '0;
            run_op(ra, rb, int'($urandom_range(0, 2)));
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
